// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and hands
// each word to decode over valid/ready, resolving beq on the consuming edge.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_halted;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_halt_op;
    logic        w_consume;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_taken    = branch & zero;
    assign w_next_pc  = w_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
    assign w_halt_op  = (r_instr[31:26] == HALT_OPCODE);
    assign w_consume  = (r_state == VALID) && instr_ready;

    // Request is a pure decode of state so it drops the same edge ack lands.
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign retired     = r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    if (w_consume) begin
                        r_retired <= r_retired + 32'd1;
                        r_valid   <= 1'b0;
                        if (w_halt_op) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, stalls, beq targets,
// halt, reset during a pending fetch, and PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;

    logic        reset_b;
    logic        ack_b;
    logic [31:0] rdata_b;
    logic        ready_b;
    logic        branch_b;
    logic        zero_b;
    logic        req_b;
    logic [31:0] addr_b;
    logic [31:0] instr_b;
    logic [5:0]  opcode_b;
    logic        valid_b;
    logic [31:0] pc_b;
    logic        halted_b;
    logic [31:0] retired_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .halted      (halted),
        .retired     (retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .imem_req    (req_b),
        .imem_addr   (addr_b),
        .imem_ack    (ack_b),
        .imem_rdata  (rdata_b),
        .instr       (instr_b),
        .opcode      (opcode_b),
        .instr_valid (valid_b),
        .instr_ready (ready_b),
        .branch      (branch_b),
        .zero        (zero_b),
        .pc          (pc_b),
        .halted      (halted_b),
        .retired     (retired_b)
    );

    // Called at a negedge in FETCH; returns at the negedge after consumption.
    task automatic fetch_consume(input logic [31:0] word,
                                 input logic br, input logic z);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        zero        = z;
        @(negedge clk);
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL reset_flags req=%b valid=%b halted=%b exp 0 0 0",
                     imem_req, instr_valid, halted);
            n_fail++;
        end
        n_run++;
        if (pc !== 32'h0 || imem_addr !== 32'h0 || instr !== 32'h0
            || retired !== 32'h0) begin
            $display("FAIL reset_regs pc=%h addr=%h instr=%h ret=%0d exp 0",
                     pc, imem_addr, instr, retired);
            n_fail++;
        end
        reset = 1'b0;
        @(negedge clk);
        n_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL reset_to_fetch req=%b addr=%h exp 1 00000000",
                     imem_req, imem_addr);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        instr_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            a = 32'(4 * (n / 2));
            n_run++;
            if (n % 2 == 0) begin
                if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
                    $display("FAIL b2b_fetch n=%0d req=%b addr=%h valid=%b exp 1 %h 0",
                             n, imem_req, imem_addr, instr_valid, a);
                    n_fail++;
                end
                imem_ack   = 1'b1;
                imem_rdata = 32'h0000_0100 | a;
            end else begin
                if (instr_valid !== 1'b1 || imem_req !== 1'b0
                    || instr !== (32'h0000_0100 | a) || opcode !== 6'h00) begin
                    $display("FAIL b2b_valid n=%0d valid=%b req=%b instr=%h exp 1 0 %h",
                             n, instr_valid, imem_req, instr, 32'h0000_0100 | a);
                    n_fail++;
                end
                imem_ack = 1'b0;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
        n_run++;
        if (retired !== 32'd3 || imem_addr !== 32'h0000_000C || imem_req !== 1'b1) begin
            $display("FAIL b2b_end ret=%0d addr=%h req=%b exp 3 0000000c 1",
                     retired, imem_addr, imem_req);
            n_fail++;
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C) begin
                $display("FAIL stall_wait i=%0d req=%b addr=%h exp 1 0000000c",
                         i, imem_req, imem_addr);
                n_fail++;
            end
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_0000;
        @(negedge clk);
        imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (instr_valid !== 1'b1 || instr !== 32'h2222_0000
                || pc !== 32'h0000_000C || imem_req !== 1'b0) begin
                $display("FAIL stall_hold i=%0d valid=%b instr=%h pc=%h req=%b exp 1 22220000 0000000c 0",
                         i, instr_valid, instr, pc, imem_req);
                n_fail++;
            end
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_run++;
        if (pc !== 32'h0000_0010 || instr_valid !== 1'b0 || retired !== 32'd4
            || imem_req !== 1'b1) begin
            $display("FAIL stall_release pc=%h valid=%b ret=%0d req=%b exp 00000010 0 4 1",
                     pc, instr_valid, retired, imem_req);
            n_fail++;
        end
    endtask

    task automatic test_branch;
        fetch_consume(32'h1000_000B, 1'b1, 1'b1);
        n_run++;
        if (imem_addr !== 32'h0000_0040) begin
            $display("FAIL br_fwd addr=%h exp 00000040", imem_addr);
            n_fail++;
        end
        fetch_consume(32'h1000_FFFF, 1'b1, 1'b1);
        n_run++;
        if (imem_addr !== 32'h0000_0040) begin
            $display("FAIL br_self addr=%h exp 00000040", imem_addr);
            n_fail++;
        end
        fetch_consume(32'h1000_0003, 1'b1, 1'b1);
        n_run++;
        if (imem_addr !== 32'h0000_0050) begin
            $display("FAIL br_off3 addr=%h exp 00000050", imem_addr);
            n_fail++;
        end
        fetch_consume(32'h1000_FFFB, 1'b1, 1'b1);
        n_run++;
        if (imem_addr !== 32'h0000_0040) begin
            $display("FAIL br_back addr=%h exp 00000040", imem_addr);
            n_fail++;
        end
        fetch_consume(32'h1000_FFFF, 1'b1, 1'b0);
        n_run++;
        if (imem_addr !== 32'h0000_0044) begin
            $display("FAIL br_not_zero addr=%h exp 00000044", imem_addr);
            n_fail++;
        end
        fetch_consume(32'h0000_0010, 1'b0, 1'b1);
        n_run++;
        if (imem_addr !== 32'h0000_0048 || retired !== 32'd10) begin
            $display("FAIL br_no_branch addr=%h ret=%0d exp 00000048 10",
                     imem_addr, retired);
            n_fail++;
        end
    endtask

    task automatic test_halt;
        logic bad;
        fetch_consume(32'hFC00_0000, 1'b0, 1'b0);
        n_run++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h0000_0048
            || retired !== 32'd11 || opcode !== 6'h3F) begin
            $display("FAIL halt_enter h=%b valid=%b pc=%h ret=%0d op=%h exp 1 0 00000048 11 3f",
                     halted, instr_valid, pc, retired, opcode);
            n_fail++;
        end
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1234_5678;
        instr_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_0048)
                bad = 1'b1;
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        n_run++;
        if (bad !== 1'b0 || retired !== 32'd11 || halted !== 1'b1
            || instr !== 32'hFC00_0000) begin
            $display("FAIL halt_frozen moved=%b ret=%0d h=%b instr=%h exp 0 11 1 fc000000",
                     bad, retired, halted, instr);
            n_fail++;
        end
        reset = 1'b1;
        #1;
        n_run++;
        if (halted !== 1'b0 || retired !== 32'd0 || pc !== 32'h0) begin
            $display("FAIL halt_reset h=%b ret=%0d pc=%h exp 0 0 00000000",
                     halted, retired, pc);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch;
        fetch_consume(32'h0000_0000, 1'b0, 1'b0);
        n_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0004) begin
            $display("FAIL rmf_pending req=%b addr=%h exp 1 00000004",
                     imem_req, imem_addr);
            n_fail++;
        end
        reset = 1'b1;
        #1;
        n_run++;
        if (instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
            $display("FAIL rmf_async valid=%b pc=%h req=%b exp 0 00000000 0",
                     instr_valid, pc, imem_req);
            n_fail++;
        end
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_run++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1
            || imem_addr !== 32'h0) begin
            $display("FAIL rmf_late_ack valid=%b instr=%h req=%b addr=%h exp 0 00000000 1 00000000",
                     instr_valid, instr, imem_req, imem_addr);
            n_fail++;
        end
        imem_rdata = 32'h0000_1234;
        @(negedge clk);
        imem_ack = 1'b0;
        n_run++;
        if (instr_valid !== 1'b1 || instr !== 32'h0000_1234 || pc !== 32'h0) begin
            $display("FAIL rmf_refetch valid=%b instr=%h pc=%h exp 1 00001234 00000000",
                     instr_valid, instr, pc);
            n_fail++;
        end
    endtask

    task automatic test_pc_wrap;
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        n_run++;
        if (req_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_start req=%b addr=%h exp 1 fffffffc", req_b, addr_b);
            n_fail++;
        end
        ack_b   = 1'b1;
        rdata_b = 32'h0000_0001;
        @(negedge clk);
        ack_b   = 1'b0;
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        n_run++;
        if (addr_b !== 32'h0 || retired_b !== 32'd1 || req_b !== 1'b1) begin
            $display("FAIL wrap_next addr=%h ret=%0d req=%b exp 00000000 1 1",
                     addr_b, retired_b, req_b);
            n_fail++;
        end
    endtask

    initial begin
        reset_b  = 1'b1;
        ack_b    = 1'b0;
        rdata_b  = 32'h0;
        ready_b  = 1'b0;
        branch_b = 1'b0;
        zero_b   = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_branch();
        test_halt();
        test_reset_mid_fetch();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder/control block.
- Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents each instruction, with its opcode field split out, to decode and control under a valid/ready handshake.
- Computes the next PC, either sequential or beq-taken, using the Branch flag from control and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode that stops fetching until the next reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; always equal to pc.
- imem_ack  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction presented to decode.
- opcode  output  6  instr[31:26], feeds the control block.
- instr_valid  output  1  instr/opcode hold a valid instruction.
- instr_ready  input  1  downstream consumes the instruction this cycle.
- branch  input  1  Branch flag from control for the current instr.
- zero  input  1  ALU zero flag for the current instr.
- pc  output  32  address of the current instruction.
- halted  output  1  HALT_OPCODE was consumed; fetch stopped.
- retired  output  32  count of instructions consumed (handshakes completed).

Behaviour:
- Reset (asynchronous, active-high, any state) drives:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired=0.
  - A reset mid-FETCH abandons the outstanding request. A late imem_ack is ignored unless the block is in FETCH.
- States are IDLE, FETCH, VALID and HALT.
- IDLE: entered only from reset. Moves to FETCH on the first clock edge after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to VALID.
  - With ack=0 the block stays in FETCH indefinitely.
  - Zero-wait memory (ack in the first FETCH cycle) gives instr_valid one cycle later.
- VALID:
  - imem_req=0, instr_valid=1, and instr/opcode held stable while instr_ready=0 (stall of any length).
  - On an edge with instr_ready=1 the instruction is consumed:
    - retired<=retired+1, wrapping mod 2^32.
    - If opcode==HALT_OPCODE: pc unchanged, instr_valid<=0, halted<=1, go to HALT.
    - Else pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc rules:
  - pc_plus4 = pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
  - If branch & zero: next_pc = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - Otherwise: next_pc = pc_plus4.
- branch and zero are sampled only on the consuming edge. branch=1 with zero=0 gives the sequential next_pc.
- HALT: all outputs frozen with halted=1, imem_req=0 and instr_valid=0. Only reset exits HALT.
- Throughput: minimum 2 cycles per instruction (one FETCH cycle, one VALID cycle) with zero-wait memory and instr_ready=1.
- Latency: imem_addr changes only on the edge that leaves VALID toward FETCH.
- opcode is combinationally instr[31:26]. It is meaningful only while instr_valid=1.
- No X on any output after reset. instr_ready, branch and zero are don't-care outside VALID.

Test Plan:
- Reset then zero-wait memory and instr_ready=1, serving 3 words at addresses 0x0, 0x4, 0x8 → imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle; retired=3.
- Memory with 3-cycle ack delay and instr_ready held low for 5 cycles in VALID → imem_req and imem_addr stable during the wait; instr held unchanged during the stall; pc advances only on the ready edge.
- beq 0x1000_FFFF at pc=0x40 with branch=1, zero=1 → next imem_addr=0x40. Same instruction with zero=0 → next imem_addr=0x44. Offset 0x0003 taken from pc=0x40 → next imem_addr=0x50.
- RESET_PC=32'hFFFF_FFFC, non-branch instruction consumed → next imem_addr=0x0000_0000.
- Assert reset during FETCH with a pending request, then ack arrives one cycle after reset release → instr_valid=0, pc=RESET_PC, the ack is ignored, and a fresh fetch of RESET_PC follows.
- Fetch 0xFC00_0000 (HALT_OPCODE) and consume it → halted=1, imem_req stays 0 for 20 cycles, retired increments by exactly 1; reset clears halted.
